// File: rtl/lambda_layer_nch_pkg.sv
// lambda_layer_nch_pkg: shared FSM states, LFSR polynomial and signed saturation for the lambda layer
// Contents: state_e (IDLE/SQRT/MAC/DONE), LFSR_MASK, SAT_MAX/SAT_MIN for the default
// 16-bit data width, sat_s() clamps a value to the signed range of a given width.
package lambda_pkg;
  typedef enum logic [1:0] {IDLE, SQRT, MAC, DONE} state_e;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam int DEF_DATA_W = 16;
  localparam longint SAT_MAX = (longint'(1) << (DEF_DATA_W - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) << (DEF_DATA_W - 1));
  function automatic longint sat_s(input longint x, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/lambda_layer_nch_isqrt_seq.sv
// isqrt_seq: restoring integer square root, one root bit per cycle, W cycles per operand
// Ports: clk, reset (sync, active high), start (loads radicand), radicand [2W],
// done (high during the final iteration; root is valid from the next cycle until the next start),
// root [W] = floor(sqrt(radicand)).
module isqrt_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*W-1:0] radicand,
  output logic           done,
  output logic [W-1:0]   root
);
  localparam int CW = $clog2(W + 1);
  logic [2*W-1:0] rad_q;
  logic [W+1:0]   rem_q;
  logic [W-1:0]   root_q;
  logic [CW-1:0]  cnt_q;
  logic [W+3:0]   rem_t;
  logic [W+1:0]   trial;
  logic           fit;
  always_comb begin
    rem_t = {rem_q, rad_q[2*W-1 -: 2]};
    trial = {root_q, 2'b01};
    fit   = rem_t >= {2'b00, trial};
  end
  // The remainder never exceeds 2*root, so the subtraction fits in W+2 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= CW'(W);
    end else if (start) begin
      rad_q  <= radicand;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
    end else if (cnt_q != CW'(W)) begin
      rad_q  <= rad_q << 2;
      rem_q  <= fit ? rem_t[W+1:0] - trial : rem_t[W+1:0];
      root_q <= {root_q[W-2:0], fit};
      cnt_q  <= cnt_q + 1'b1;
    end
  end
  assign done = cnt_q == CW'(W - 1);
  assign root = root_q;
endmodule

// File: rtl/lambda_layer_nch.sv
// lambda_layer_nch: multi-channel VAE reparameterisation z = mean + sqrt(var) * eps, saturated
// Ports: clk, reset (sync, active high); in_valid/in_ready with packed mean_in/var_in
// (channel 0 in LSBs); out_valid/out_ready with packed lambda_out; busy in SQRT/MAC.
// Build option LAMBDA_LAYER_EXT_EPS_EN: adds eps_in (N_CH*EPS_W, packed signed Q2.FRAC)
// captured at the input handshake and replaces the internal Galois LFSR.
module lambda_layer_nch
  import lambda_pkg::*;
#(
  parameter int          N_CH      = 4,
  parameter int          DATA_W    = 16,
  parameter int          FRAC      = 8,
  parameter int          EPS_W     = FRAC + 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH*DATA_W-1:0] mean_in,
  input  logic [N_CH*DATA_W-1:0] var_in,
`ifdef LAMBDA_LAYER_EXT_EPS_EN
  input  logic [N_CH*EPS_W-1:0]  eps_in,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_CH*DATA_W-1:0] lambda_out,
  output logic                   busy
);
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int PW   = DATA_W + EPS_W + 2;
  state_e                   state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d, ch_nx;
  logic [N_CH*DATA_W-1:0]   mean_q, var_q, lambda_q;
  logic                     hs, start, sq_done, last;
  logic [DATA_W-1:0]        std, var_sel;
  logic [2*DATA_W-1:0]      rad;
  logic signed [EPS_W-1:0]  eps;
  logic signed [DATA_W-1:0] mean_ch, z;
  logic signed [PW-1:0]     prod, sum;
  assign hs    = in_valid && in_ready;
  assign last  = ch_q == CH_W'(N_CH - 1);
  assign ch_nx = ch_q + 1'b1;
  // The root unit is loaded on the handshake edge for channel 0 and on each MAC edge for the
  // next channel, so every channel costs exactly DATA_W SQRT cycles plus one MAC cycle.
  assign var_sel = state_q == IDLE ? var_in[DATA_W-1:0] : var_q[ch_nx*DATA_W +: DATA_W];
  assign rad     = (2*DATA_W)'({var_sel, {FRAC{1'b0}}});
  assign start   = hs || (state_q == MAC && !last);
  isqrt_seq #(.W(DATA_W)) u_sqrt (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .radicand(rad),
    .done    (sq_done),
    .root    (std)
  );
`ifdef LAMBDA_LAYER_EXT_EPS_EN
  logic [N_CH*EPS_W-1:0] eps_q;
  assign eps = eps_q[ch_q*EPS_W +: EPS_W];
  always_ff @(posedge clk) begin
    if (reset) eps_q <= '0;
    else if (hs) eps_q <= eps_in;
  end
`else
  logic [15:0] lfsr_q, lfsr_d;
  assign eps    = lfsr_q[EPS_W-1:0];
  assign lfsr_d = state_q == MAC ? (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000) : lfsr_q;
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED == 16'h0000 ? 16'h0001 : LFSR_SEED;
    else lfsr_q <= lfsr_d;
  end
`endif
  always_comb begin
    mean_ch = mean_q[ch_q*DATA_W +: DATA_W];
    prod    = $signed(PW'({1'b0, std})) * PW'(eps);
    sum     = PW'(mean_ch) + (prod >>> FRAC);
    z       = DATA_W'(sat_s(longint'(sum), DATA_W));
  end
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = SQRT;
        ch_d    = '0;
      end
      SQRT: if (sq_done) state_d = MAC;
      MAC: begin
        state_d = last ? DONE : SQRT;
        ch_d    = last ? ch_q : ch_nx;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      mean_q   <= '0;
      var_q    <= '0;
      lambda_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      if (hs) begin
        mean_q <= mean_in;
        var_q  <= var_in;
      end
      if (state_q == MAC) lambda_q[ch_q*DATA_W +: DATA_W] <= z;
    end
  end
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign busy       = state_q == SQRT || state_q == MAC;
  assign lambda_out = lambda_q;
endmodule

// File: tb/tb_lambda_layer_nch.sv
// tb_lambda_layer_nch: randomized and directed checks of lambda_layer_nch against an arithmetic reference model
module tb_lambda_layer_nch;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] mean_in, var_in, lambda_out;
  logic [39:0] eps_in;
  logic [15:0] m_lfsr;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  lambda_layer_nch dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mean_in   (mean_in),
    .var_in    (var_in),
`ifdef LAMBDA_LAYER_EXT_EPS_EN
    .eps_in    (eps_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lambda_out(lambda_out),
    .busy      (busy)
  );

  // z = clamp(mean + floor(floor(sqrt(var*256)) * eps / 256)), eps from eps_in or the LFSR sequence
  function automatic logic [63:0] model(input logic [63:0] m, input logic [63:0] v, input logic [39:0] e);
    logic [63:0] r;
    r = '0;
    for (int c = 0; c < N; c++) begin
      longint x, s, ep, z;
      logic signed [15:0] ms;
      logic signed [9:0] es;
      x = longint'(v[c*16 +: 16]) * 256;
      s = longint'($floor($sqrt(real'(x))));
      while (s * s > x) s--;
      while ((s + 1) * (s + 1) <= x) s++;
`ifdef LAMBDA_LAYER_EXT_EPS_EN
      es = e[c*10 +: 10];
`else
      es = m_lfsr[9:0] ^ 10'(e & 40'h0);
      m_lfsr = m_lfsr[0] ? (m_lfsr >> 1) ^ 16'hB400 : m_lfsr >> 1;
`endif
      ep = es;
      ms = m[c*16 +: 16];
      z = longint'(ms) + ((s * ep) >>> 8);
      if (z > 32767) z = 32767;
      if (z < -32768) z = -32768;
      r[c*16 +: 16] = z[15:0];
    end
    return r;
  endfunction

  task automatic reset_dut;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic send(input logic [63:0] m, input logic [63:0] v, input logic [39:0] e, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    mean_in = m;
    var_in = v;
    eps_in = e;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [63:0] got, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 300);
    got = lambda_out;
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input logic [63:0] m, input logic [63:0] v, input logic [39:0] e,
                         output logic [63:0] got, output int lat, output bit ok);
    send(m, v, e, ok);
    wait_result(got, lat);
    release_out();
  endtask

  task automatic test_reset;
    reset_dut();
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (lambda_out !== 64'h0) $display("FAIL reset_lambda got %h want 0", lambda_out); else passed++;
  endtask

  task automatic test_directed;
    logic [63:0] dm[3] = '{64'h0100, 64'h7F00, 64'h8100};
    logic [63:0] dv[3] = '{64'h0400, 64'hFFFF, 64'h1000};
    logic [39:0] de[3] = '{40'h080, 40'h180, 40'h200};
    logic [63:0] dz[3] = '{64'h0200, 64'h7FFF, 64'h8000};
    logic [63:0] got, exp;
    int lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      run_vec(dm[i], dv[i], de[i], got, lat, ok);
      exp = model(dm[i], dv[i], de[i]);
      checks++; if (!ok) $display("FAIL directed_accept vec %0d in_ready never high", i); else passed++;
      checks++; if (lat !== 68) $display("FAIL directed_latency vec %0d got %0d want 68", i, lat); else passed++;
      checks++; if (got !== exp) $display("FAIL directed_model vec %0d got %h want %h", i, got, exp); else passed++;
`ifdef LAMBDA_LAYER_EXT_EPS_EN
      checks++; if (got !== dz[i]) $display("FAIL directed_const vec %0d got %h want %h", i, got, dz[i]); else passed++;
`else
      if (dz[i] === 64'hx) $display("unused %h", dz[i]);
`endif
    end
  endtask

  task automatic test_var_zero;
    logic [63:0] m, got, exp;
    int lat;
    bit ok;
    m = {16'h0123, 16'hFF00, 16'h0000, 16'h7FFF};
    run_vec(m, 64'h0, {$urandom, 8'($urandom)}, got, lat, ok);
    exp = model(m, 64'h0, eps_in);
    checks++; if (got !== m) $display("FAIL var_zero got %h want %h", got, m); else passed++;
    checks++; if (got !== exp) $display("FAIL var_zero_model got %h want %h", got, exp); else passed++;
  endtask

  task automatic test_backpressure;
    logic [63:0] ma, va, mb, vb, got, expa, expb;
    logic [39:0] ea, eb;
    int lat, bad;
    bit ok;
    ma = {$urandom, $urandom}; va = {$urandom, $urandom}; ea = {$urandom, 8'($urandom)};
    mb = {$urandom, $urandom}; vb = {$urandom, $urandom}; eb = {$urandom, 8'($urandom)};
    send(ma, va, ea, ok);
    wait_result(got, lat);
    expa = model(ma, va, ea);
    checks++; if (got !== expa) $display("FAIL bp_first got %h want %h", got, expa); else passed++;
    mean_in = mb; var_in = vb; eps_in = eb; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || lambda_out !== expa) begin
        if (bad++ < 3) $display("FAIL bp_hold cycle %0d got v=%b r=%b b=%b z=%h want v=1 r=0 b=0 z=%h",
                                i, out_valid, in_ready, busy, lambda_out, expa);
      end else passed++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); else passed++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(got, lat);
    expb = model(mb, vb, eb);
    checks++; if (lat !== 68) $display("FAIL bp_second_latency got %0d want 68", lat); else passed++;
    checks++; if (got !== expb) $display("FAIL bp_second got %h want %h", got, expb); else passed++;
    release_out();
  endtask

  task automatic test_reset_mid;
    logic [63:0] m, v, got, exp;
    logic [39:0] e;
    int lat;
    bit ok;
    m = {$urandom, $urandom}; v = {$urandom, $urandom}; e = {$urandom, 8'($urandom)};
    send(m, v, e, ok);
    repeat (38) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL mid_busy got b=%b v=%b want b=1 v=0", busy, out_valid); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || lambda_out !== 64'h0)
      $display("FAIL mid_reset got r=%b v=%b b=%b z=%h want r=1 v=0 b=0 z=0", in_ready, out_valid, busy, lambda_out);
    else passed++;
    reset = 1'b0;
    m_lfsr = 16'hACE1;
    run_vec(m, v, e, got, lat, ok);
    exp = model(m, v, e);
    checks++; if (lat !== 68) $display("FAIL mid_after_latency got %0d want 68", lat); else passed++;
    checks++; if (got !== exp) $display("FAIL mid_after got %h want %h", got, exp); else passed++;
  endtask

  task automatic test_lfsr_repeat;
    logic [63:0] v, r1, r2, r3, e1, e2;
    int lat;
    bit ok;
    v = {4{16'h4000}};
    reset_dut();
    run_vec(64'h0, v, 40'h3FF_00_0001, r1, lat, ok);
    e1 = model(64'h0, v, 40'h3FF_00_0001);
    run_vec(64'h0, v, 40'h3FF_00_0001, r2, lat, ok);
    e2 = model(64'h0, v, 40'h3FF_00_0001);
    checks++; if (r1 !== e1) $display("FAIL lfsr_first got %h want %h", r1, e1); else passed++;
    checks++; if (r2 !== e2) $display("FAIL lfsr_second got %h want %h", r2, e2); else passed++;
`ifndef LAMBDA_LAYER_EXT_EPS_EN
    checks++; if (r1 === r2) $display("FAIL lfsr_differs got %h twice want different", r1); else passed++;
`endif
    reset_dut();
    run_vec(64'h0, v, 40'h3FF_00_0001, r3, lat, ok);
    checks++; if (r3 !== e1) $display("FAIL lfsr_rerun got %h want %h", r3, e1); else passed++;
    if (model(64'h0, v, 40'h0) === 64'hx) $display("unreachable");
  endtask

  task automatic test_random;
    logic [63:0] m, v, got, exp;
    logic [39:0] e;
    int lat;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      m = {$urandom, $urandom};
      v = {$urandom, $urandom} >> $urandom_range(0, 12);
      e = {$urandom, 8'($urandom)};
      run_vec(m, v, e, got, lat, ok);
      exp = model(m, v, e);
      checks++; if (lat !== 68) $display("FAIL random_latency vec %0d got %0d want 68", i, lat); else passed++;
      checks++; if (got !== exp) $display("FAIL random vec %0d got %h want %h", i, got, exp); else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mean_in = '0;
    var_in = '0;
    eps_in = '0;
    m_lfsr = 16'hACE1;
    test_reset();
    test_directed();
    test_var_zero();
    test_backpressure();
    test_reset_mid();
    test_lfsr_repeat();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
